// File: rtl/adpcm_addc_pkg.sv
// adpcm_addc_pkg: shared ADPCM widths and small helpers used by the
// reconstruction-path blocks.
package adpcm_addc_pkg;

   // Quantized difference, sign-magnitude (sign in MSB).
   localparam int unsigned DqWidth  = 16;
   // Partial signal estimate, two's complement.
   localparam int unsigned SezWidth = 15;
   // Internal sum width; carry-out beyond this is discarded.
   localparam int unsigned SumWidth = 16;

   // Sign-extend the partial signal estimate to the sum width.
   function automatic logic [SumWidth-1:0] sez_ext(input logic [SezWidth-1:0] sez);
      return {{(SumWidth - SezWidth){sez[SezWidth-1]}}, sez};
   endfunction

endpackage

// File: rtl/adpcm_sm2tc.sv
// adpcm_sm2tc: sign-magnitude to two's-complement converter.
// Ports:
//   sm_i - sign-magnitude input, MSB is the sign (1 = negative)
//   tc_o - two's-complement result; negative zero maps to zero
module adpcm_sm2tc
   import adpcm_addc_pkg::*;
(
   input  logic [DqWidth-1:0] sm_i,
   output logic [DqWidth-1:0] tc_o
);

   logic [DqWidth-1:0] mag;

   assign mag = {1'b0, sm_i[DqWidth-2:0]};

   // Negating a zero magnitude yields zero, so negative zero needs no special case.
   always_comb begin
      tc_o = mag;
      if (sm_i[DqWidth-1]) begin
         tc_o = (~mag) + {{(DqWidth-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/adpcm_addc.sv
// adpcm_addc: adds the quantized difference DQ (sign-magnitude) to the partial
// signal estimate SEZ (two's complement) and reports the sign and zero-ness
// of the wrapped 16-bit sum. Purely combinational; clk/reset and scan ports
// exist only for the uniform block interface and later scan stitching.
// Ports:
//   clk, reset            - block clock / synchronous active-high reset (unused)
//   DQ                    - quantized difference, sign-magnitude
//   SEZ                   - partial signal estimate, two's complement
//   PK0                   - sign of DQ+SEZ (1 = negative)
//   SIGPK                 - 1 when DQ+SEZ is zero
//   scan_enable/test_mode - DFT controls, no functional effect
//   scan_in0..4           - scan chain inputs
//   scan_out0..4          - scan chain outputs, tied low until DFT insertion
module adpcm_addc
   import adpcm_addc_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [DqWidth-1:0]  DQ,
   input  logic [SezWidth-1:0] SEZ,
   output logic                PK0,
   output logic                SIGPK,
   input  logic                scan_enable,
   input  logic                test_mode,
   input  logic                scan_in0,
   input  logic                scan_in1,
   input  logic                scan_in2,
   input  logic                scan_in3,
   input  logic                scan_in4,
   output logic                scan_out0,
   output logic                scan_out1,
   output logic                scan_out2,
   output logic                scan_out3,
   output logic                scan_out4
);

   logic [DqWidth-1:0]  dqi;
   logic [SumWidth-1:0] sezi;
   logic [SumWidth-1:0] dqsez;

   adpcm_sm2tc u_sm2tc (
      .sm_i (DQ),
      .tc_o (dqi)
   );

   assign sezi  = sez_ext(SEZ);
   // Modulo-2^16 add: carry-out dropped, no saturation.
   assign dqsez = dqi + sezi;

   assign PK0   = dqsez[SumWidth-1];
   assign SIGPK = (dqsez == '0);

   assign scan_out0 = 1'b0;
   assign scan_out1 = 1'b0;
   assign scan_out2 = 1'b0;
   assign scan_out3 = 1'b0;
   assign scan_out4 = 1'b0;

   // Interface-only inputs, reduced so they are visibly consumed.
   logic unused_inputs;
   assign unused_inputs = ^{clk, reset, scan_enable, test_mode,
                            scan_in0, scan_in1, scan_in2, scan_in3, scan_in4};

endmodule

// File: tb/tb_adpcm_addc.sv
module tb_adpcm_addc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] DQ = '0;
   logic [14:0] SEZ = '0;
   logic        PK0;
   logic        SIGPK;
   logic        scan_enable = 1'b0;
   logic        test_mode = 1'b0;
   logic        scan_in0 = 1'b0;
   logic        scan_in1 = 1'b0;
   logic        scan_in2 = 1'b0;
   logic        scan_in3 = 1'b0;
   logic        scan_in4 = 1'b0;
   logic        scan_out0;
   logic        scan_out1;
   logic        scan_out2;
   logic        scan_out3;
   logic        scan_out4;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   adpcm_addc dut (
      .clk         (clk),
      .reset       (reset),
      .DQ          (DQ),
      .SEZ         (SEZ),
      .PK0         (PK0),
      .SIGPK       (SIGPK),
      .scan_enable (scan_enable),
      .test_mode   (test_mode),
      .scan_in0    (scan_in0),
      .scan_in1    (scan_in1),
      .scan_in2    (scan_in2),
      .scan_in3    (scan_in3),
      .scan_in4    (scan_in4),
      .scan_out0   (scan_out0),
      .scan_out1   (scan_out1),
      .scan_out2   (scan_out2),
      .scan_out3   (scan_out3),
      .scan_out4   (scan_out4)
   );

   // Reference: signed integer arithmetic, then reduce modulo 2^16.
   function automatic logic [15:0] ref_sum(input logic [15:0] dq, input logic [14:0] sez);
      int dq_val;
      int sez_val;
      int total;
      logic [31:0] t;
      dq_val  = int'(dq[14:0]);
      if (dq[15]) dq_val = -dq_val;
      sez_val = int'(sez);
      if (sez[14]) sez_val = sez_val - 32768;
      total = dq_val + sez_val;
      t = 32'(total);
      return t[15:0];
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_assert++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Apply at rising edge, check every output at the following falling edge.
   task automatic apply(input logic [15:0] dq, input logic [14:0] sez,
                        input logic exp_pk, input logic exp_sig, input string tag);
      @(posedge clk);
      DQ  = dq;
      SEZ = sez;
      @(negedge clk);
      chk({tag, " PK0"},   {15'd0, PK0},   {15'd0, exp_pk});
      chk({tag, " SIGPK"}, {15'd0, SIGPK}, {15'd0, exp_sig});
      chk({tag, " scan_out"},
          {11'd0, scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}, 16'd0);
   endtask

   task automatic apply_model(input logic [15:0] dq, input logic [14:0] sez, input string tag);
      logic [15:0] s;
      s = ref_sum(dq, sez);
      apply(dq, sez, s[15], (s == 16'h0000), tag);
   endtask

   initial begin
      // Outputs follow inputs even while reset is held.
      apply(16'h0000, 15'h0000, 1'b0, 1'b1, "zero_in_reset");
      reset = 1'b0;
      apply(16'h0000, 15'h0000, 1'b0, 1'b1, "zero");
      apply(16'h8000, 15'h0000, 1'b0, 1'b1, "neg_zero");
      apply(16'h0010, 15'h7FF0, 1'b0, 1'b1, "cancel");
      apply(16'h8005, 15'h0003, 1'b1, 1'b0, "neg_sum");
      apply(16'h7FFF, 15'h3FFF, 1'b1, 1'b0, "wrap_neg");
      apply(16'h3FFF, 15'h3FFF, 1'b0, 1'b0, "wrap_pos");
      apply(16'hFFFF, 15'h4000, 1'b0, 1'b0, "min_min");
      apply(16'h8001, 15'h0001, 1'b0, 1'b1, "neg_cancel");

      // Random vectors with reset pulsed mid-stream and DFT controls toggling.
      for (int i = 0; i < 200; i++) begin
         logic [15:0] dq;
         logic [14:0] sez;
         dq  = 16'($urandom);
         sez = 15'($urandom);
         if (i % 10 == 3) sez = 15'(-int'(dq[14:0]) * (dq[15] ? -1 : 1));
         reset       = ((i % 17) >= 5 && (i % 17) <= 7);
         scan_enable = 1'($urandom);
         test_mode   = 1'($urandom);
         scan_in0    = 1'($urandom);
         scan_in1    = 1'($urandom);
         scan_in2    = 1'($urandom);
         scan_in3    = 1'($urandom);
         scan_in4    = 1'($urandom);
         apply_model(dq, sez, $sformatf("rand%0d", i));
      end

      reset = 1'b0;
      apply_model(16'h8005, 15'h0003, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
